// File: rtl/diagram_pkg.sv
// Shared types and default sizes for the motor-position diagram path
// (sample producer, scheduler and pixel renderer).
package diagram_pkg;
  localparam int DEFAULT_SAMPLE_WIDTH = 8;
  localparam int DEFAULT_DEPTH        = 1024;
  localparam int DEFAULT_ADDR_BITS    = $clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [DEFAULT_ADDR_BITS-1:0]    ring_addr_t;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO staging producer samples until the RAM port is free.
// The head is shown combinationally on dout; a push while full is dropped.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[head];

  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/diagram_sample_scheduler.sv
// Shares one single-port sample RAM between the motor sample producer (ring
// writes) and the diagram renderer (frame-relative reads, absolute priority).
module diagram_sample_scheduler
  import diagram_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    video_vsync,
  input  logic                    smp_valid,
  output logic                    smp_ready,
  input  logic [SAMPLE_WIDTH-1:0] smp_data,
  input  logic                    rd_en,
  input  logic [ADDR_BITS-1:0]    rd_index,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_BITS-1:0]    ram_addr,
  output logic [SAMPLE_WIDTH-1:0] ram_wdata,
  input  logic [SAMPLE_WIDTH-1:0] ram_rdata,
  output logic [ADDR_BITS-1:0]    frame_base,
  output logic                    ring_full
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [SAMPLE_WIDTH-1:0] fifo_dout;
  logic                    do_write;
  logic [ADDR_BITS-1:0]    wr_ptr;
  logic [ADDR_BITS-1:0]    wr_ptr_next;
  logic                    vsync_prev;
  logic                    vsync_rise;
  logic                    rd_pipe;

  // Producer handshake: a sample moves on a clock edge where smp_valid and
  // smp_ready are both high; smp_ready depends only on registered FIFO state.
  assign smp_ready = !fifo_full;

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (smp_valid),
    .pop   (do_write),
    .din   (smp_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = wr_ptr;
    ram_wdata = fifo_dout;
    do_write  = 1'b0;
    if (!reset) begin
      if (rd_en) begin
        ram_en   = 1'b1;
        ram_addr = frame_base + rd_index;
      end else if (!fifo_empty) begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        do_write = 1'b1;
      end
    end
  end

  assign wr_ptr_next = do_write ? wr_ptr + ADDR_BITS'(1) : wr_ptr;
  assign vsync_rise  = video_vsync && !vsync_prev;

  // A write landing on the vsync edge is already counted in wr_ptr_next,
  // so it belongs to the new frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      ring_full  <= 1'b0;
      vsync_prev <= 1'b0;
      frame_base <= '0;
      rd_pipe    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      vsync_prev <= video_vsync;
      if (do_write && wr_ptr == LAST_ADDR) ring_full <= 1'b1;
      if (vsync_rise) frame_base <= ring_full ? wr_ptr_next : '0;
      rd_pipe  <= rd_en;
      rd_valid <= rd_pipe;
      if (rd_pipe) rd_data <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_diagram_sample_scheduler.sv
// Bench for diagram_sample_scheduler: RAM model, scoreboard queues for writes
// and reads, directed frame-lock and reset scenarios.
module tb_diagram_sample_scheduler;
  localparam int SW = 8;
  localparam int DEPTH = 1024;
  localparam int AB = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          video_vsync = 1'b0;
  logic          smp_valid = 1'b0;
  logic          smp_ready;
  logic [SW-1:0] smp_data = '0;
  logic          rd_en = 1'b0;
  logic [AB-1:0] rd_index = '0;
  logic          rd_valid;
  logic [SW-1:0] rd_data;
  logic          ram_en;
  logic          ram_we;
  logic [AB-1:0] ram_addr;
  logic [SW-1:0] ram_wdata;
  logic [SW-1:0] ram_rdata = '0;
  logic [AB-1:0] frame_base;
  logic          ring_full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cnt = 0;

  logic [SW-1:0]    ram_mem [DEPTH];
  logic [SW-1:0]    ref_mem [DEPTH];
  logic [AB-1:0]    exp_wr_ptr = '0;
  logic [AB+SW-1:0] exp_q[$];
  logic [AB-1:0]    rd_addr_q[$];
  logic [SW-1:0]    rd_data_q[$];
  int               rd_cyc_q[$];

  diagram_sample_scheduler #(
    .SAMPLE_WIDTH (SW),
    .DEPTH        (DEPTH),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .video_vsync (video_vsync),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .smp_data    (smp_data),
    .rd_en       (rd_en),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .frame_base  (frame_base),
    .ring_full   (ring_full)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clock) begin
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
    else if (ram_en) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    logic [AB+SW-1:0] e;
    if (reset) begin
      check("ram_en_in_reset", ram_en, 0);
    end else begin
      if (ram_en && ram_we) begin
        if (exp_q.size() == 0) check("wr_unexpected", ram_we, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", ram_addr, e[AB+SW-1:SW]);
          check("wr_data", ram_wdata, e[SW-1:0]);
        end
      end
      if (rd_en) begin
        check("rd_port", {ram_en, ram_we}, 2'b10);
        if (rd_addr_q.size() > 0) check("rd_addr", ram_addr, rd_addr_q.pop_front());
        rd_cyc_q.push_back(cyc);
      end
      if (rd_valid) begin
        if (rd_data_q.size() == 0) check("rd_unexpected", rd_valid, 0);
        else begin
          check("rd_data", rd_data, rd_data_q.pop_front());
          check("rd_latency", cyc, rd_cyc_q.pop_front() + 2);
        end
      end
      if (smp_valid && smp_ready) begin
        exp_q.push_back({exp_wr_ptr, smp_data});
        ref_mem[exp_wr_ptr] = smp_data;
        exp_wr_ptr++;
        accept_cnt++;
      end
    end
  end

  // driver tasks
  task automatic apply_reset(input int n);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_rd_valid", rd_valid, 0);
    repeat (n) @(posedge clock);
    exp_q.delete();
    rd_addr_q.delete();
    rd_data_q.delete();
    rd_cyc_q.delete();
    exp_wr_ptr = '0;
    #1 reset = 1'b0;
  endtask

  task automatic push_sample(input logic [SW-1:0] d);
    int n = 0;
    smp_valid = 1'b1;
    smp_data  = d;
    @(negedge clock);
    while (!smp_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!smp_ready) check("push_timeout", smp_ready, 1);
    @(posedge clock);
    #1 smp_valid = 1'b0;
  endtask

  task automatic read_idx(input logic [AB-1:0] idx, input logic [AB-1:0] base);
    logic [AB-1:0] a;
    a = base + idx;
    rd_addr_q.push_back(a);
    rd_data_q.push_back(ref_mem[a]);
    rd_en    = 1'b1;
    rd_index = idx;
    @(posedge clock);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_vsync();
    video_vsync = 1'b1;
    @(posedge clock);
    #1 video_vsync = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rd_data_q.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", exp_q.size() + rd_data_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc0;
    apply_reset(3);
    @(negedge clock);
    check("rst_smp_ready", smp_ready, 1);
    check("rst_rd_valid2", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_base", frame_base, 0);
    check("rst_ring_full", ring_full, 0);
    check("rst_ram_en", ram_en, 0);
    @(posedge clock);
    #1;

    // three samples write to 0,1,2 on consecutive cycles
    push_sample(8'h11);
    push_sample(8'h22);
    push_sample(8'h33);
    check("wr_back_to_back", exp_q.size(), 1);
    drain();
    check("ring_full_early", ring_full, 0);

    // reads saturate the port while the producer fills the FIFO
    acc0 = accept_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) read_idx(AB'(i % 3), '0);
        check("accepts_during_rd", accept_cnt - acc0, 4);
        check("ready_low_full", smp_ready, 0);
      end
      begin
        for (int i = 0; i < 6; i++) push_sample(SW'(8'h40 + i));
      end
    join
    drain();
    check("accepts_total", accept_cnt - acc0, 6);

    // prefill the whole ring with data = address, then wrap by 5
    apply_reset(2);
    for (int i = 0; i < DEPTH; i++) push_sample(SW'(i));
    for (int i = 0; i < 5; i++) push_sample(SW'(8'hA0 + i));
    drain();
    check("ring_full_set", ring_full, 1);
    check("fb_no_vsync", frame_base, 0);
    pulse_vsync();
    check("fb_after_wrap", frame_base, 5);
    read_idx('0, AB'(5));
    drain();

    // frame base near the top of the ring, reads wrap through zero
    for (int i = 0; i < DEPTH - 9; i++) push_sample(SW'($urandom_range(0, 255)));
    drain();
    pulse_vsync();
    check("fb_top", frame_base, DEPTH - 4);
    read_idx(AB'(3), AB'(DEPTH - 4));
    read_idx(AB'(4), AB'(DEPTH - 4));
    read_idx(AB'(5), AB'(DEPTH - 4));
    drain();

    // write and vsync rise in the same cycle with wr_ptr = 7
    for (int i = 0; i < 11; i++) push_sample(SW'($urandom_range(0, 255)));
    drain();
    push_sample(8'h5A);
    video_vsync = 1'b1;
    @(posedge clock);
    #1 video_vsync = 1'b0;
    @(negedge clock);
    check("fb_same_cycle_write", frame_base, 8);
    drain();

    // reset lands while a read is in flight
    rd_addr_q.push_back(AB'(8));
    rd_en    = 1'b1;
    rd_index = '0;
    @(posedge clock);
    #1 rd_en = 1'b0;
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rd_valid_after_rst", rd_valid, 0);
    end
    check("fb_after_rst", frame_base, 0);
    check("ring_full_after_rst", ring_full, 0);
    check("ready_after_rst", smp_ready, 1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
